universal_register_ne: RTL and testbench
========================================

# universal_register_ne

Parametrised WIDTH-bit register clocked on the falling edge of C, with an 8-function mode select: hold, shift, rotate, parallel load and up/down count. It extends the single-bit negative-edge D flip-flop to a multi-bit datapath and adds asynchronous clear. It serves as the general storage, serial-conversion and counting element for later lab datapaths.

## Interface
- WIDTH, 4, register width in bits; legal values are 2 or greater.
- C  input  1  clock; all state updates on the falling edge.
- CLR  input  1  asynchronous, active-high reset.
- EN  input  1  synchronous enable; when 0, hold regardless of M.
- M  input  3  mode select (see Operation).
- D  input  WIDTH  parallel load data.
- SIR  input  1  serial input for shift right (enters at the MSB).
- SIL  input  1  serial input for shift left (enters at the LSB).
- Q  output  WIDTH  register state.
- Qnot  output  WIDTH  bitwise complement of Q, always.
- SOR  output  1  Q[0], the bit that leaves on shift right.
- SOL  output  1  Q[WIDTH-1], the bit that leaves on shift left.
- TC  output  1  terminal count (combinational, see below).

## Operation
- Reset: while CLR=1, Q=0, Qnot=all ones, SOR=0, SOL=0 and TC=0. CLR overrides C, EN and M at all times.
- On each falling edge of C with CLR=0 and EN=1, the next Q is set by M:
  - 000 hold: Q unchanged.
  - 001 shift right: Q <= {SIR, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], SIL}.
  - 011 parallel load: Q <= D.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 count up: Q <= Q+1 modulo 2^WIDTH; all ones wraps to 0.
  - 111 count down: Q <= Q-1 modulo 2^WIDTH; 0 wraps to all ones.
- Arithmetic is unsigned WIDTH-bit with no carry storage. Wrap is signalled only through TC.
- TC = EN & ((M==110 & Q==all ones) | (M==111 & Q==0)). TC is 0 in every other mode. TC is combinational from current Q, M and EN. Cascading counters: drive the next stage's EN from TC.
- Qnot, SOR and SOL are derived combinationally from Q only. They never differ from Q between edges.
- EN=0 or M=000 gives identical behaviour: no state change.
- Rising edges of C have no effect on state.

## Timing
- Latency: Q reflects the selected operation immediately after the falling edge of C on which it was sampled. This is one-edge latency.
- D, M, EN, SIR and SIL are sampled only at the falling edge. They must be stable around that edge, and changes while C is high or low are ignored.
- CLR assertion: Q goes to 0 immediately, without waiting for an edge, including during any mode or mid-shift sequence. Any partially shifted or counted value is lost.
- CLR deassertion: the first state update is the first falling edge of C after CLR=0.
- CLR deasserted coincident with a falling edge: that edge is ignored and Q stays 0.
- Serial out: after a shift edge, SOR/SOL show the new end bits. The bit shifted out is visible on SOR/SOL before that edge, so a cascaded stage can sample it on the same edge.

## Test plan
- Reset: WIDTH=4, drive Q to 1010, then assert CLR between edges -> Q=0000 and Qnot=1111 immediately. Hold CLR through 3 falling edges with M=011, D=1111 -> Q stays 0000.
- Load/shift: load D=1011 (M=011). Shift right with SIR=0 for 4 edges -> Q=0101, 0010, 0001, 0000, and SOR before each edge = 1, 1, 0, 1. Then shift left with SIL=1 for 2 edges -> 0001, 0011.
- Rotate: load 1000, rotate left 4 edges -> 0001, 0010, 0100, 1000. Rotate right 1 edge -> 0100.
- Count with wrap: load 1110, M=110 -> TC=0. Next edge gives Q=1111 and TC=1, next edge Q=0000. Switch to M=111 -> TC=1, next edge Q=1111.
- Enable/edge polarity: EN=0 with M=110 for 5 edges -> Q unchanged and TC=0. EN=1 with C toggled only low-to-high -> no change.
- Width generality: WIDTH=8, load 0xFF and count up -> TC=1, then 0x00. Shift left with SIL=1 from 0x00 for 8 edges -> 0xFF.

Source files
------------

// File: rtl/universal_register_ne.sv
// Falling-edge universal register with async clear.
// Modes: hold, shift, rotate, load and up/down count.
module universal_register_ne #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             SOR,
  output logic             SOL,
  output logic             TC
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DN   = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [7:0]       mode_dec;
  logic             is_up;
  logic             is_dn;
  logic             at_ones;
  logic             at_zero;

  assign mode_dec = 8'b1 << M;

  always_comb begin
    q_nxt = q_r;
    if (EN) begin
      unique case (1'b1)
        mode_dec[MODE_SHR]:  q_nxt = {SIR, q_r[WIDTH-1:1]};
        mode_dec[MODE_SHL]:  q_nxt = {q_r[WIDTH-2:0], SIL};
        mode_dec[MODE_LOAD]: q_nxt = D;
        mode_dec[MODE_ROR]:  q_nxt = {q_r[0], q_r[WIDTH-1:1]};
        mode_dec[MODE_ROL]:  q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        mode_dec[MODE_UP]:   q_nxt = q_r + ONE;
        mode_dec[MODE_DN]:   q_nxt = q_r - ONE;
        default:             q_nxt = q_r;
      endcase
    end
  end

  always_ff @(negedge C or posedge CLR) begin
    if (CLR) q_r <= ZERO;
    else     q_r <= q_nxt;
  end

  assign is_up   = mode_dec[MODE_UP];
  assign is_dn   = mode_dec[MODE_DN];
  assign at_ones = (q_r == ONES);
  assign at_zero = (q_r == ZERO);

  // Gate with CLR so TC is low throughout reset, not just after q_r settles.
  assign TC   = ~CLR & EN &
                ((is_up & at_ones) | (is_dn & at_zero));
  assign Q    = q_r;
  assign Qnot = ~q_r;
  assign SOR  = q_r[0];
  assign SOL  = q_r[WIDTH-1];

endmodule

// File: tb/tb_universal_register_ne.sv
// Bench for universal_register_ne: directed plan
// plus randomized run against an arithmetic model.
module tb_universal_register_ne;

  logic       C, CLR, EN, SIR, SIL;
  logic [2:0] M;
  logic [3:0] D4, Q4, Qn4;
  logic [7:0] D8, Q8, Qn8;
  logic       SOR4, SOL4, TC4;
  logic       SOR8, SOL8, TC8;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned m4, m8;

  universal_register_ne #(.WIDTH(4)) dut4 (
    .C(C), .CLR(CLR), .EN(EN), .M(M), .D(D4),
    .SIR(SIR), .SIL(SIL), .Q(Q4), .Qnot(Qn4),
    .SOR(SOR4), .SOL(SOL4), .TC(TC4)
  );

  universal_register_ne #(.WIDTH(8)) dut8 (
    .C(C), .CLR(CLR), .EN(EN), .M(M), .D(D8),
    .SIR(SIR), .SIL(SIL), .Q(Q8), .Qnot(Qn8),
    .SOR(SOR8), .SOL(SOL8), .TC(TC8)
  );

  function automatic int unsigned mnext(
    int unsigned q, int w, logic [2:0] m,
    int unsigned d, logic sir, logic sil);
    int unsigned mask, top, r;
    mask = (32'd1 << w) - 1;
    top  = 32'd1 << (w - 1);
    case (m)
      3'd1: r = (q >> 1) + (sir ? top : 0);
      3'd2: r = ((q * 2) + sil) % (mask + 1);
      3'd3: r = d % (mask + 1);
      3'd4: r = (q >> 1) + ((q % 2) ? top : 0);
      3'd5: r = ((q * 2) + (q / top)) % (mask + 1);
      3'd6: r = (q + 1) % (mask + 1);
      3'd7: r = (q + mask) % (mask + 1);
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic logic mtc(
    int unsigned q, int w, logic [2:0] m, logic en);
    int unsigned mask;
    mask = (32'd1 << w) - 1;
    if (!en) return 1'b0;
    if (m == 3'd6) return q == mask;
    if (m == 3'd7) return q == 0;
    return 1'b0;
  endfunction

  // one full clock cycle ending on a falling edge
  task automatic tick();
    C = 1'b1;
    #5;
    if (!CLR && EN) begin
      m4 = mnext(m4, 4, M, D4, SIR, SIL);
      m8 = mnext(m8, 8, M, D8, SIR, SIL);
    end
    C = 1'b0;
    #5;
  endtask

  task automatic load(input logic [3:0] v4,
                      input logic [7:0] v8);
    EN = 1'b1; M = 3'b011; D4 = v4; D8 = v8;
    tick();
  endtask

  task automatic test_reset();
    CLR = 1'b1; C = 1'b0; EN = 1'b1; M = 3'b111;
    #3;
    n_cmp++;
    if (Q4 !== 4'h0 || Qn4 !== 4'hF || SOR4 !== 1'b0 ||
        SOL4 !== 1'b0 || TC4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: Q=%h Qn=%h SOR=%b SOL=%b TC=%b want 0 F 0 0 0",
               Q4, Qn4, SOR4, SOL4, TC4);
    end
    #2;
    CLR = 1'b0; m4 = 0; m8 = 0;
    load(4'b1010, 8'hA5);
    n_cmp++;
    if (Q4 !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_preload: got %b want 1010", Q4);
    end
    #2;
    CLR = 1'b1; m4 = 0; m8 = 0;
    #1;
    n_cmp++;
    if (Q4 !== 4'h0 || Qn4 !== 4'hF || Q8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: Q=%h Qn=%h Q8=%h want 0 F 00",
               Q4, Qn4, Q8);
    end
    M = 3'b011; D4 = 4'hF; D8 = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (Q4 !== 4'h0 || Q8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: Q=%h Q8=%h want 0 00", Q4, Q8);
    end
    CLR = 1'b0;
    #1;
  endtask

  task automatic test_load_shift();
    logic [3:0] exp_q [4];
    logic       exp_so [4];
    exp_q  = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    exp_so = '{1'b1, 1'b1, 1'b0, 1'b1};
    load(4'b1011, 8'h00);
    M = 3'b001; SIR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (SOR4 !== exp_so[i]) begin
        n_fail++;
        $display("FAIL shr_sor[%0d]: got %b want %b",
                 i, SOR4, exp_so[i]);
      end
      tick();
      n_cmp++;
      if (Q4 !== exp_q[i]) begin
        n_fail++;
        $display("FAIL shr_q[%0d]: got %b want %b",
                 i, Q4, exp_q[i]);
      end
    end
    M = 3'b010; SIL = 1'b1;
    tick();
    n_cmp++;
    if (Q4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL shl_q0: got %b want 0001", Q4);
    end
    tick();
    n_cmp++;
    if (Q4 !== 4'b0011 || SOL4 !== 1'b0) begin
      n_fail++;
      $display("FAIL shl_q1: got %b SOL=%b want 0011 0",
               Q4, SOL4);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q [4];
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    load(4'b1000, 8'h00);
    M = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (Q4 !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rol_q[%0d]: got %b want %b",
                 i, Q4, exp_q[i]);
      end
    end
    M = 3'b100;
    tick();
    n_cmp++;
    if (Q4 !== 4'b0100) begin
      n_fail++;
      $display("FAIL ror_q: got %b want 0100", Q4);
    end
  endtask

  task automatic test_count_wrap();
    load(4'b1110, 8'h00);
    M = 3'b110;
    #1;
    n_cmp++;
    if (TC4 !== 1'b0) begin
      n_fail++;
      $display("FAIL up_tc0: got %b want 0", TC4);
    end
    tick();
    n_cmp++;
    if (Q4 !== 4'b1111 || TC4 !== 1'b1) begin
      n_fail++;
      $display("FAIL up_tc1: Q=%b TC=%b want 1111 1", Q4, TC4);
    end
    tick();
    n_cmp++;
    if (Q4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL up_wrap: got %b want 0000", Q4);
    end
    M = 3'b111;
    #1;
    n_cmp++;
    if (TC4 !== 1'b1) begin
      n_fail++;
      $display("FAIL dn_tc: got %b want 1", TC4);
    end
    tick();
    n_cmp++;
    if (Q4 !== 4'b1111) begin
      n_fail++;
      $display("FAIL dn_wrap: got %b want 1111", Q4);
    end
  endtask

  task automatic test_enable_edge();
    EN = 1'b0; M = 3'b110;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (Q4 !== 4'b1111 || TC4 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold: Q=%b TC=%b want 1111 0", Q4, TC4);
    end
    EN = 1'b1; M = 3'b011; D4 = 4'b0101;
    C = 1'b1;
    #5;
    n_cmp++;
    if (Q4 !== 4'b1111) begin
      n_fail++;
      $display("FAIL rise_only: got %b want 1111", Q4);
    end
    EN = 1'b0;
    #1;
    C = 1'b0;
    #5;
    n_cmp++;
    if (Q4 !== 4'b1111) begin
      n_fail++;
      $display("FAIL rise_then_fall_en0: got %b want 1111", Q4);
    end
  endtask

  task automatic test_width8();
    load(4'h0, 8'hFF);
    M = 3'b110;
    #1;
    n_cmp++;
    if (TC8 !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_tc: got %b want 1", TC8);
    end
    tick();
    n_cmp++;
    if (Q8 !== 8'h00) begin
      n_fail++;
      $display("FAIL w8_wrap: got %h want 00", Q8);
    end
    M = 3'b010; SIL = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (Q8 !== 8'hFF || Qn8 !== 8'h00) begin
      n_fail++;
      $display("FAIL w8_shl: Q=%h Qn=%h want FF 00", Q8, Qn8);
    end
  endtask

  task automatic test_random();
    m4 = Q4;
    m8 = Q8;
    for (int i = 0; i < 300; i++) begin
      EN  = ($urandom_range(0, 7) != 0);
      M   = 3'($urandom_range(0, 7));
      D4  = 4'($urandom);
      D8  = 8'($urandom);
      SIR = 1'($urandom);
      SIL = 1'($urandom);
      #1;
      n_cmp++;
      if (TC4 !== mtc(m4, 4, M, EN) ||
          TC8 !== mtc(m8, 8, M, EN) ||
          SOR4 !== m4[0] || SOL4 !== m4[3] ||
          SOR8 !== m8[0] || SOL8 !== m8[7]) begin
        n_fail++;
        $display("FAIL rnd_comb[%0d]: TC=%b%b SO4=%b%b SO8=%b%b m4=%h m8=%h M=%0d EN=%b",
                 i, TC4, TC8, SOL4, SOR4, SOL8, SOR8,
                 m4, m8, M, EN);
      end
      tick();
      n_cmp++;
      if (Q4 !== 4'(m4) || Qn4 !== ~4'(m4) ||
          Q8 !== 8'(m8) || Qn8 !== ~8'(m8)) begin
        n_fail++;
        $display("FAIL rnd_q[%0d]: Q4=%h Q8=%h want %h %h",
                 i, Q4, Q8, 4'(m4), 8'(m8));
      end
      if ($urandom_range(0, 19) == 0) begin
        CLR = 1'b1; m4 = 0; m8 = 0;
        #1;
        n_cmp++;
        if (Q4 !== 4'h0 || Q8 !== 8'h00 || TC4 !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_clr[%0d]: Q4=%h Q8=%h TC=%b want 0 00 0",
                   i, Q4, Q8, TC4);
        end
        CLR = 1'b0;
        #1;
      end
    end
  endtask

  initial begin
    C = 1'b0; CLR = 1'b1; EN = 1'b0; M = 3'b000;
    D4 = '0; D8 = '0; SIR = 1'b0; SIL = 1'b0;
    m4 = 0; m8 = 0;
    test_reset();
    test_load_shift();
    test_rotate();
    test_count_wrap();
    test_enable_edge();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
